// File: rtl/ms11_burst_feeder.sv
// Burst-summing producer for the TestMasterSlave11 consumer: sums BURST_LEN samples
// into a frame and publishes it. Optional clamping arithmetic via `MS11_FEEDER_SAT_EN.
module ms11_burst_feeder #(
  parameter int BURST_LEN   = 4,
  parameter int SYNC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] m_in,
  input  logic               m_in_valid,
  output logic               m_in_ready,
  output logic signed [31:0] s_out,
  output logic               s_out_sync,
  output logic               shared_out,
  output logic               sat_flag
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = $clog2(SYNC_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BURST_LEN - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CYCLES);

  typedef enum logic [0:0] {
    SEC_ACCUM = 1'b0,
    SEC_EMIT  = 1'b1
  } state_t;

  state_t        r_state;
  logic [31:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sync_cnt;
  logic [31:0]   r_s_out;
  logic          r_sync;
  logic          r_shared;
  logic          r_ready;

  state_t        w_state_nxt;
  logic [31:0]   w_acc_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] w_sync_cnt_nxt;
  logic [31:0]   w_s_out_nxt;
  logic          w_sync_nxt;
  logic          w_shared_nxt;
  logic [31:0]   w_sum;
  logic          w_xfer;
  logic          w_last;
  logic          w_emit_done;

`ifdef MS11_FEEDER_SAT_EN
  logic w_clamp;
  logic r_sat;
  logic w_sat_nxt;

  // Two's complement add clamped to the signed 32-bit range; bit 32 flags a clamp.
  function automatic logic [32:0] add_sat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic        ovf;
    s   = a + b;
    ovf = (a[31] == b[31]) && (s[31] != a[31]);
    if (ovf) begin
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      s = s;
    end
    return {ovf, s};
  endfunction

  assign {w_clamp, w_sum} = add_sat(r_acc, m_in);
`else
  function automatic logic [31:0] add_wrap(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign w_sum = add_wrap(r_acc, m_in);
`endif

  assign w_xfer      = m_in_valid && r_ready;
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_emit_done = (r_sync_cnt == SYNC_LAST);

  // Next-state and next-output decode for the accumulate/emit sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_sync_cnt_nxt = r_sync_cnt;
    w_s_out_nxt    = r_s_out;
    w_sync_nxt     = r_sync;
    w_shared_nxt   = r_shared;
    case (r_state)
      SEC_ACCUM: begin
        if (w_xfer && w_last) begin
          w_s_out_nxt    = w_sum;
          w_sync_nxt     = 1'b1;
          w_sync_cnt_nxt = SW'(1);
          w_cnt_nxt      = {CW{1'b0}};
          w_acc_nxt      = 32'h0000_0000;
          w_state_nxt    = SEC_EMIT;
        end else if (w_xfer) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      SEC_EMIT: begin
        if (w_emit_done) begin
          w_sync_nxt   = 1'b0;
          w_shared_nxt = ~r_shared;
          w_state_nxt  = SEC_ACCUM;
        end else begin
          w_sync_cnt_nxt = r_sync_cnt + SW'(1);
          w_sync_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = SEC_ACCUM;
        w_acc_nxt      = 32'h0000_0000;
        w_cnt_nxt      = {CW{1'b0}};
        w_sync_cnt_nxt = {SW{1'b0}};
        w_sync_nxt     = 1'b0;
      end
    endcase
  end

  // Sequencer state, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SEC_ACCUM;
      r_acc      <= 32'h0000_0000;
      r_cnt      <= {CW{1'b0}};
      r_sync_cnt <= {SW{1'b0}};
      r_s_out    <= 32'h0000_0000;
      r_sync     <= 1'b0;
      r_shared   <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_s_out    <= w_s_out_nxt;
      r_sync     <= w_sync_nxt;
      r_shared   <= w_shared_nxt;
      // ready tracks the state register exactly, so it never depends on m_in_valid
      r_ready    <= (w_state_nxt == SEC_ACCUM);
    end
  end

`ifdef MS11_FEEDER_SAT_EN
  // Saturation indicator: sticky within a frame, dropped when the frame retires.
  always_comb begin
    w_sat_nxt = r_sat;
    case (r_state)
      SEC_ACCUM: begin
        if (w_xfer && w_clamp) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_sat_nxt = r_sat;
        end
      end
      SEC_EMIT: begin
        if (w_emit_done) begin
          w_sat_nxt = 1'b0;
        end else begin
          w_sat_nxt = r_sat;
        end
      end
      default: w_sat_nxt = 1'b0;
    endcase
  end

  // Saturation flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_sat_nxt;
    end
  end

  assign sat_flag = r_sat;
`else
  assign sat_flag = 1'b0;
`endif

  assign m_in_ready = r_ready;
  assign s_out      = r_s_out;
  assign s_out_sync = r_sync;
  assign shared_out = r_shared;

endmodule

// File: tb/tb_ms11_burst_feeder.sv
// Self-checking bench: three feeder configurations checked every cycle against a
// frame-level model, plus directed scenarios with hand-computed expectations.
module tb_ms11_burst_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din [3];
  logic [2:0]  valid;
  wire  [2:0]  ready, sync, shared, sat;
  wire  [31:0] dout [3];

  always #5 clk = ~clk;

  ms11_burst_feeder #(.BURST_LEN(4), .SYNC_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .m_in(din[0]), .m_in_valid(valid[0]), .m_in_ready(ready[0]),
    .s_out(dout[0]), .s_out_sync(sync[0]), .shared_out(shared[0]), .sat_flag(sat[0]));
  ms11_burst_feeder #(.BURST_LEN(4), .SYNC_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .m_in(din[1]), .m_in_valid(valid[1]), .m_in_ready(ready[1]),
    .s_out(dout[1]), .s_out_sync(sync[1]), .shared_out(shared[1]), .sat_flag(sat[1]));
  ms11_burst_feeder #(.BURST_LEN(1), .SYNC_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .m_in(din[2]), .m_in_valid(valid[2]), .m_in_ready(ready[2]),
    .s_out(dout[2]), .s_out_sync(sync[2]), .shared_out(shared[2]), .sat_flag(sat[2]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Frame-level model: per instance, samples collected so far, their running sum,
  // the last published frame, and how many sync cycles of the current frame remain.
  int          bl [3] = '{4, 4, 1};
  int          sc [3] = '{1, 3, 1};
  int          m_n [3];
  int          m_left [3];
  logic [31:0] m_sum [3];
  logic [31:0] m_out [3];
  logic        m_sh [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_left[k] = 0; m_sum[k] = 32'd0; m_out[k] = 32'd0; m_sh[k] = 1'b0;
    end
  endfunction

  initial begin
    logic [2:0]  cap_v;
    logic [31:0] cap_d [3];
    model_reset();
    forever begin
      @(posedge clk);
      cap_v = valid;
      for (int k = 0; k < 3; k++) cap_d[k] = din[k];
      #1;
      if (!rst) begin
        model_reset();
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) m_sh[k] = ~m_sh[k];
          end else if (cap_v[k]) begin
            m_sum[k] = m_sum[k] + cap_d[k];
            m_n[k]++;
            if (m_n[k] == bl[k]) begin
              m_out[k] = m_sum[k]; m_sum[k] = 32'd0; m_n[k] = 0; m_left[k] = sc[k];
            end
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ready%0d", k), {31'd0, ready[k]}, {31'd0, m_left[k] == 0});
        chk($sformatf("sync%0d", k), {31'd0, sync[k]}, {31'd0, m_left[k] > 0});
        chk($sformatf("shared%0d", k), {31'd0, shared[k]}, {31'd0, m_sh[k]});
        chk($sformatf("s_out%0d", k), dout[k], m_out[k]);
        chk($sformatf("sat%0d", k), {31'd0, sat[k]}, 32'd0);
      end
    end
  end

  // Offer one sample to instance k and hold it until accepted; returns at the
  // falling edge following the accepting rising edge, with valid still high.
  task automatic send(input int k, input logic [31:0] d);
    bit acc;
    int waited = 0;
    din[k] = d;
    valid[k] = 1'b1;
    forever begin
      acc = ready[k];
      @(negedge clk);
      if (acc) break;
      waited++;
      if (waited > 40) begin
        checks++; errors++;
        $display("FAIL send_timeout inst=%0d actual=no_accept required=accept", k);
        valid[k] = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int k, input int n);
    valid[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [31:0] r;
    logic [31:0] v6 [3];
    logic        sh6 [3];
    v6  = '{32'd9, 32'd8, 32'd7};
    sh6 = '{1'b1, 1'b0, 1'b1};
    rst = 1'b0;
    valid = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'd0, ready}, 32'd7);
    chk("rst_sout", dout[0], 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back 1,2,3,4
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3); send(0, 32'd4);
    valid[0] = 1'b0;
    chk("t1_sout", dout[0], 32'd10);
    chk("t1_sync", {31'd0, sync[0]}, 32'd1);
    chk("t1_ready", {31'd0, ready[0]}, 32'd0);
    chk("t1_shared_before", {31'd0, shared[0]}, 32'd0);
    @(negedge clk);
    chk("t1_sync_off", {31'd0, sync[0]}, 32'd0);
    chk("t1_shared_after", {31'd0, shared[0]}, 32'd1);
    chk("t1_ready_back", {31'd0, ready[0]}, 32'd1);

    // Gapped 5,-3,7,1
    send(0, 32'd5); idle(0, 2); send(0, -32'sd3); idle(0, 2);
    send(0, 32'd7); idle(0, 2); send(0, 32'd1);
    valid[0] = 1'b0;
    chk("t2_sout", dout[0], 32'd10);
    chk("t2_sync", {31'd0, sync[0]}, 32'd1);
    @(negedge clk);
    chk("t2_shared", {31'd0, shared[0]}, 32'd0);

    // SYNC_CYCLES=3 with valid held high through the frame
    send(1, 32'd1); send(1, 32'd2); send(1, 32'd3); send(1, 32'd4);
    din[1] = 32'd100;
    chk("t3_sout", dout[1], 32'd10);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (sync[1]) cnt++;
      @(negedge clk);
    end
    valid[1] = 1'b0;
    chk("t3_sync_cycles", cnt, 32'd3);

    // Wrap-around of 4 x max positive
    repeat (4) send(0, 32'h7FFF_FFFF);
    valid[0] = 1'b0;
    chk("t4_sout_wrap", dout[0], 32'hFFFF_FFFC);
    chk("t4_sat", {31'd0, sat[0]}, 32'd0);
    @(negedge clk);

    // Reset mid-burst, then a clean frame
    send(0, 32'd3); send(0, 32'd3);
    valid[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_rst_sout", dout[0], 32'd0);
    chk("t5_rst_shared", {29'd0, shared}, 32'd0);
    chk("t5_rst_sync", {29'd0, sync}, 32'd0);
    chk("t5_rst_ready", {29'd0, ready}, 32'd7);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) send(0, 32'd1);
    valid[0] = 1'b0;
    chk("t5_sout", dout[0], 32'd4);
    chk("t5_shared", {31'd0, shared[0]}, 32'd0);
    @(negedge clk);
    chk("t5_shared_after", {31'd0, shared[0]}, 32'd1);

    // BURST_LEN=1 streaming 9,8,7
    for (int i = 0; i < 3; i++) begin
      send(2, v6[i]);
      valid[2] = 1'b0;
      chk($sformatf("t6_sout%0d", i), dout[2], v6[i]);
      @(negedge clk);
      chk($sformatf("t6_shared%0d", i), {31'd0, shared[2]}, {31'd0, sh6[i]});
    end

    // Randomized traffic across all three configurations
    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0: r = 32'h7FFF_FFFF;
        1: r = 32'h8000_0000;
        default: r = $urandom;
      endcase
      send(k, r);
      idle(k, $urandom_range(0, 2));
    end

    valid = 3'b000;
    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
